// File: rtl/mdu_pkg.sv
// MDU shared types: op codes, FSM states and op-class helpers.
// Used by mdu and mdu_div_core.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_RSV6  = 3'b110,
      OP_RSV7  = 3'b111
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } mdu_state_t;

   function automatic logic op_is_signed(mdu_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_mul(mdu_op_t op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic op_is_div(mdu_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on operand magnitudes, with sign fix-up and
// divide-by-zero / signed-overflow results; quo/rem show post-step values.
module mdu_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);
   import mdu_pkg::*;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   // Load magnitudes and flags, or perform one restoring step.
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      dvd_d  = dvd_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      zero_d = zero_q;
      ovf_d  = ovf_q;
      rem_sh = '0;
      diff   = '0;
      if (load) begin
         rem_d  = '0;
         quo_d  = (sgn && a[WIDTH-1]) ? -a : a;
         dvs_d  = (sgn && b[WIDTH-1]) ? -b : b;
         dvd_d  = a;
         qneg_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
         rneg_d = sgn && a[WIDTH-1];
         zero_d = (b == '0);
         ovf_d  = sgn && (a == MIN_NEG) && (b == '1);
      end else if (step) begin
         rem_sh = {rem_q, quo_q[WIDTH-1]};
         diff   = rem_sh - {1'b0, dvs_q};
         if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Final results with special cases and sign restoration.
   always_comb begin
      quo = qneg_q ? -quo_d : quo_d;
      rem = rneg_q ? -rem_d : rem_d;
      if (zero_q) begin
         quo = '1;
         rem = dvd_q;
      end else if (ovf_q) begin
         quo = dvd_q;
         rem = '0;
      end
   end

   // Divider state register, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         dvd_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         dvd_q  <= dvd_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers.
// Divide support is built only when MDU_DIVIDE_EN is defined.
module mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import mdu_pkg::*;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mdu_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   mdu_op_t            op_in;
   logic               sgn_in;

   assign op_in  = mdu_op_t'(op);
   assign sgn_in = op_is_signed(op_in);
   assign busy   = (state_q == MUL) || (state_q == DIV);
   assign done   = (state_q == FIN);
   assign hi     = hi_q;
   assign lo     = lo_q;

`ifdef MDU_DIVIDE_EN
   logic             div_load;
   logic             div_step;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] div_rem;

   mdu_div_core #(.WIDTH(WIDTH)) u_div (
      .clk   (clk),
      .reset (reset),
      .load  (div_load),
      .step  (div_step),
      .sgn   (sgn_in),
      .a     (a),
      .b     (b),
      .quo   (div_quo),
      .rem   (div_rem)
   );
`endif

   // Next-state, shift-add multiply step and HI/LO writeback.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      sum     = '0;
      prod    = '0;
`ifdef MDU_DIVIDE_EN
      div_load = 1'b0;
      div_step = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               neg_d = sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
               if (op_is_mul(op_in)) begin
                  state_d = MUL;
                  mcand_d = (sgn_in && a[WIDTH-1]) ? -a : a;
                  acc_d   = {{WIDTH{1'b0}},
                             (sgn_in && b[WIDTH-1]) ? -b : b};
               end
`ifdef MDU_DIVIDE_EN
               else if (op_is_div(op_in)) begin
                  state_d  = DIV;
                  div_load = 1'b1;
               end
`endif
               else begin
                  state_d = FIN;
                  if (op_in == OP_MTHI) hi_d = a;
                  if (op_in == OP_MTLO) lo_d = a;
               end
            end
         end
         MUL: begin
            sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, acc_q[0] ? mcand_q : {WIDTH{1'b0}}};
            acc_d = {sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = FIN;
               prod    = neg_q ? -acc_d : acc_d;
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
            end
         end
`ifdef MDU_DIVIDE_EN
         DIV: begin
            div_step = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = FIN;
               hi_d    = div_rem;
               lo_d    = div_quo;
            end
         end
`endif
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and architectural registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table, random ops vs a
// reference model, plus busy-ignore and mid-op reset sequences.
module tb_mdu;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors;
   int checks;

   logic [31:0] mhi;
   logic [31:0] mlo;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   mdu #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural result from the instruction definitions.
   task automatic model(input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        inout logic [31:0] h,
                        inout logic [31:0] l,
                        output int lat);
      longint      sp;
      logic [63:0] up;
      int          sx;
      int          sy;
      lat = 1;
      case (o)
         3'd0: begin
            sp  = longint'($signed(x)) * longint'($signed(y));
            up  = 64'(sp);
            h   = up[63:32];
            l   = up[31:0];
            lat = 33;
         end
         3'd1: begin
            up  = {32'd0, x} * {32'd0, y};
            h   = up[63:32];
            l   = up[31:0];
            lat = 33;
         end
`ifdef MDU_DIVIDE_EN
         3'd2, 3'd3: begin
            lat = 33;
            if (y == 32'd0) begin
               l = 32'hffffffff;
               h = x;
            end else if (o == 3'd2 && x == 32'h80000000 &&
                         y == 32'hffffffff) begin
               l = x;
               h = 32'd0;
            end else if (o == 3'd2) begin
               sx = $signed(x);
               sy = $signed(y);
               l  = 32'(sx / sy);
               h  = 32'(sx % sy);
            end else begin
               l = x / y;
               h = x % y;
            end
         end
`endif
         3'd4: h = x;
         3'd5: l = x;
         default: ;
      endcase
   endtask

   // Issue one op from an idle negedge and check timing and result.
   task automatic run_op(input logic [2:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [31:0] ehi,
                         input logic [31:0] elo,
                         input int elat,
                         input string tag);
      logic [31:0] ohi;
      logic [31:0] olo;
      int          lat;
      int          nbusy;
      logic        hold_bad;
      ohi      = hi;
      olo      = lo;
      lat      = 0;
      nbusy    = 0;
      hold_bad = 1'b0;
      start    = 1'b1;
      op       = o;
      a        = x;
      b        = y;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd0;
      a     = 32'd0;
      b     = 32'd0;
      for (int c = 1; c <= 100; c++) begin
         if (done) begin
            lat = c;
            break;
         end
         if (busy) nbusy++;
         if (hi !== ohi || lo !== olo) hold_bad = 1'b1;
         @(negedge clk);
      end
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      chk({tag, " busy_cycles"}, 64'(nbusy), 64'(elat - 1));
      chk({tag, " hilo_hold"}, 64'(hold_bad), 64'd0);
      chk({tag, " hi"}, 64'(hi), 64'(ehi));
      chk({tag, " lo"}, 64'(lo), 64'(elo));
      @(negedge clk);
   endtask

   initial begin
      logic [2:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] ph;
      logic [31:0] pl;
      logic [31:0] old_lo;
      int          lat;

      errors = 0;
      checks = 0;
      reset  = 1'b0;
      start  = 1'b0;
      op     = 3'd0;
      a      = 32'd0;
      b      = 32'd0;
      mhi    = 32'd0;
      mlo    = 32'd0;

      repeat (2) @(negedge clk);
      start = 1'b1;
      op    = 3'd4;
      a     = 32'h55;
      @(negedge clk);
      start = 1'b0;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      vecs.push_back('{3'd0, 32'hffffffff, 32'h2,
                       32'hffffffff, 32'hfffffffe, 33});
      vecs.push_back('{3'd1, 32'hffffffff, 32'h2,
                       32'h00000001, 32'hfffffffe, 33});
      vecs.push_back('{3'd4, 32'h12345678, 32'h0,
                       32'h12345678, 32'hfffffffe, 1});
      vecs.push_back('{3'd5, 32'h9abcdef0, 32'h0,
                       32'h12345678, 32'h9abcdef0, 1});
      vecs.push_back('{3'd6, 32'hdeadbeef, 32'h1,
                       32'h12345678, 32'h9abcdef0, 1});
      vecs.push_back('{3'd0, 32'h80000000, 32'h80000000,
                       32'h40000000, 32'h00000000, 33});
      vecs.push_back('{3'd1, 32'hffffffff, 32'hffffffff,
                       32'hfffffffe, 32'h00000001, 33});
`ifdef MDU_DIVIDE_EN
      vecs.push_back('{3'd2, 32'hfffffff9, 32'h2,
                       32'hffffffff, 32'hfffffffd, 33});
      vecs.push_back('{3'd3, 32'h5, 32'h0,
                       32'h00000005, 32'hffffffff, 33});
      vecs.push_back('{3'd2, 32'h80000000, 32'hffffffff,
                       32'h00000000, 32'h80000000, 33});
      vecs.push_back('{3'd2, 32'h7, 32'hfffffffe,
                       32'h00000001, 32'hfffffffd, 33});
      vecs.push_back('{3'd2, 32'hfffffff9, 32'h0,
                       32'hfffffff9, 32'hffffffff, 33});
`else
      vecs.push_back('{3'd2, 32'hfffffff9, 32'h2,
                       32'hfffffffe, 32'h00000001, 1});
      vecs.push_back('{3'd3, 32'h5, 32'h0,
                       32'hfffffffe, 32'h00000001, 1});
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         model(vecs[i].op, vecs[i].a, vecs[i].b, mhi, mlo, lat);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].lat,
                $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 3));
         else y = $urandom;
         if ($urandom_range(0, 7) == 0) x = 32'h80000000;
         model(o, x, y, mhi, mlo, lat);
         run_op(o, x, y, mhi, mlo, lat, $sformatf("rnd%0d", i));
      end

      // MTLO issued while a MULTU is busy must be dropped.
      old_lo = mlo;
      x      = 32'h00010003;
      y      = 32'h00050007;
      ph     = mhi;
      pl     = mlo;
      model(3'd1, x, y, ph, pl, lat);
      start = 1'b1;
      op    = 3'd1;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         if (c == 32) begin
            chk("busy_ign busy@32", 64'(busy), 64'd1);
            chk("busy_ign lo@32", 64'(lo), 64'(old_lo));
         end
         if (c == 33) begin
            chk("busy_ign done@33", 64'(done), 64'd1);
            chk("busy_ign hi@33", 64'(hi), 64'(ph));
            chk("busy_ign lo@33", 64'(lo), 64'(pl));
         end
         if (c == 34) begin
            chk("busy_ign done@34", 64'(done), 64'd0);
            chk("busy_ign lo@34", 64'(lo), 64'(pl));
         end
         if (c == 5) begin
            start = 1'b1;
            op    = 3'd5;
            a     = 32'h1234;
         end else begin
            start = 1'b0;
            op    = 3'd0;
            a     = 32'd0;
         end
         @(negedge clk);
      end
      mhi = ph;
      mlo = pl;

      // Reset in the middle of a long operation.
`ifdef MDU_DIVIDE_EN
      o = 3'd3;
`else
      o = 3'd1;
`endif
      start = 1'b1;
      op    = o;
      a     = 32'h00abcdef;
      b     = 32'h00000013;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         if (c == 10) begin
            chk("midrst busy@10", 64'(busy), 64'd1);
            reset = 1'b0;
         end
         if (c == 11) begin
            chk("midrst busy", 64'(busy), 64'd0);
            chk("midrst done", 64'(done), 64'd0);
            chk("midrst hi", 64'(hi), 64'd0);
            chk("midrst lo", 64'(lo), 64'd0);
            reset = 1'b1;
         end
         @(negedge clk);
      end
      mhi = 32'd0;
      mlo = 32'd0;
      model(3'd4, 32'h0000cafe, 32'd0, mhi, mlo, lat);
      run_op(3'd4, 32'h0000cafe, 32'd0,
             32'h0000cafe, 32'h00000000, 1, "mthi_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
